// File: rtl/decoder_3to8_pulse.sv
// Receive side of the 8-to-3 encoder link: buffers 3-bit codes in a 2-entry FIFO
// and replays each as a one-hot pulse of PULSE_LEN cycles followed by GAP_LEN idle cycles.
module decoder_3to8_pulse #(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i,
   input  logic       i_valid,
   output logic       i_ready,
   output logic [7:0] y,
   output logic       y_valid,
   output logic       busy,
   output logic [7:0] seen,
   input  logic       seen_clr
);

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_LOAD   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] y_nxt;
   logic       pop, push;

   logic [2:0] fifo_mem [2];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;
   logic [7:0] head_onehot;

   // Ready comes from the registered count only, so a full FIFO stays closed even on a pop.
   assign i_ready     = (count != 2'd2) && !rst;
   assign push        = i_valid && i_ready;
   assign head_onehot = 8'b1 << fifo_mem[rd_ptr];
   assign y_valid     = |y;
   assign busy        = (state != IDLE) || (count != 2'd0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      y_nxt     = y;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            y_nxt = '0;
            if (count != 2'd0) begin
               pop       = 1'b1;
               y_nxt     = head_onehot;
               cnt_nxt   = PULSE_LOAD;
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else if (GAP_LEN != 0) begin
               y_nxt     = '0;
               cnt_nxt   = GAP_LOAD;
               state_nxt = GAP;
            end else if (count != 2'd0) begin
               pop     = 1'b1;
               y_nxt   = head_onehot;
               cnt_nxt = PULSE_LOAD;
            end else begin
               y_nxt     = '0;
               state_nxt = IDLE;
            end
         end
         GAP: begin
            y_nxt = '0;
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else if (count != 2'd0) begin
               pop       = 1'b1;
               y_nxt     = head_onehot;
               cnt_nxt   = PULSE_LOAD;
               state_nxt = PULSE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            y_nxt     = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         y     <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         y     <= y_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // A clear in the same cycle as a pop keeps only the line just issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen <= '0;
      end else if (pop) begin
         seen <= seen_clr ? head_onehot : (seen | head_onehot);
      end else if (seen_clr) begin
         seen <= '0;
      end
   end

endmodule
